// File: rtl/bounce_controller.sv
// bounce_controller
//   Per-frame motion scheduler for the screensaver sprite. Each new value seen on the
//   frame counter schedules one position update. The update steps x, then y, then
//   commits both at once. A hit on any edge reflects that axis and advances the
//   colour index. Position and colour change only at commit or on a config load, so
//   they stay stable while a frame is being scanned out.
//
// Ports
//   clk        pixel clock
//   rst        asynchronous reset, active low
//   frame      frame counter from the video timer; any change is a tick
//   pause      1 = discard ticks
//   cfg_valid  configuration load request; taken when cfg_ready is also high
//   cfg_ready  configuration can be accepted this cycle
//   cfg_x/y    new position (clamped to the screen limits)
//   cfg_speed  new speed in pixels/frame
//   cfg_dir    {dir_x, dir_y}; 1 = right/down
//   sprite_x/y sprite top-left corner
//   color_idx  colour index 0..N_COLORS-1
//   bounce     one-cycle pulse, an edge was hit by the last update
//   corner     one-cycle pulse, x and y were both hit by the last update
//   busy       an update is in progress
module bounce_controller #(
   parameter int unsigned SCREEN_W = 640,
   parameter int unsigned SCREEN_H = 480,
   parameter int unsigned SPRITE_W = 64,
   parameter int unsigned SPRITE_H = 32,
   parameter int unsigned SPEED    = 1,
   parameter int unsigned START_X  = 0,
   parameter int unsigned START_Y  = 0,
   parameter int unsigned N_COLORS = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] frame,
   input  logic        pause,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic [9:0]  cfg_x,
   input  logic [8:0]  cfg_y,
   input  logic [2:0]  cfg_speed,
   input  logic [1:0]  cfg_dir,
   output logic [9:0]  sprite_x,
   output logic [8:0]  sprite_y,
   output logic [2:0]  color_idx,
   output logic        bounce,
   output logic        corner,
   output logic        busy
);

   localparam logic [10:0] XMax = 11'(SCREEN_W - SPRITE_W);
   localparam logic [10:0] YMax = 11'(SCREEN_H - SPRITE_H);

   typedef enum logic [1:0] {StIdle, StStepX, StStepY, StCommit} state_e;

   state_e      state_q, state_d;
   logic [31:0] frame_q;
   logic        armed_q;
   logic        pending_q, pending_d;
   logic [9:0]  x_q, x_d, nx_q, nx_d;
   logic [8:0]  y_q, y_d, ny_q, ny_d;
   logic [1:0]  dir_q, dir_d;
   logic [2:0]  speed_q, speed_d;
   logic [2:0]  color_q, color_d;
   logic        hx_q, hx_d, hy_q, hy_d;
   logic        bounce_q, bounce_d, corner_q, corner_d;

   logic        tick, tick_run;
   logic [10:0] x_w, y_w, spd_w, cfg_x_w, cfg_y_w;

   // Nothing is compared against frame_q until it has been loaded once after reset.
   assign tick     = armed_q & (frame != frame_q);
   assign tick_run = tick & ~pause;

   // 11-bit views so the edge comparisons cannot wrap.
   assign x_w     = {1'b0, x_q};
   assign y_w     = {2'b0, y_q};
   assign spd_w   = {8'b0, speed_q};
   assign cfg_x_w = {1'b0, cfg_x};
   assign cfg_y_w = {2'b0, cfg_y};

   // armed_q keeps cfg_ready low in reset and in the first cycle after release.
   assign cfg_ready = armed_q & (state_q == StIdle) & ~pending_q & ~tick;

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      x_d       = x_q;
      y_d       = y_q;
      nx_d      = nx_q;
      ny_d      = ny_q;
      hx_d      = hx_q;
      hy_d      = hy_q;
      dir_d     = dir_q;
      speed_d   = speed_q;
      color_d   = color_q;
      bounce_d  = 1'b0;
      corner_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (pending_q || tick_run) begin
               pending_d = 1'b0;
               state_d   = StStepX;
            end else if (cfg_valid && cfg_ready) begin
               x_d     = (cfg_x_w > XMax) ? XMax[9:0] : cfg_x;
               y_d     = (cfg_y_w > YMax) ? YMax[8:0] : cfg_y;
               speed_d = cfg_speed;
               dir_d   = cfg_dir;
            end
         end
         StStepX: begin
            nx_d = x_q;
            hx_d = 1'b0;
            // Speed zero never registers a hit, even sitting on a limit.
            if (speed_q != 3'd0) begin
               if (dir_q[1]) begin
                  if (x_w + spd_w >= XMax) begin
                     nx_d     = XMax[9:0];
                     dir_d[1] = 1'b0;
                     hx_d     = 1'b1;
                  end else begin
                     nx_d = x_q + 10'(speed_q);
                  end
               end else if (x_w <= spd_w) begin
                  nx_d     = 10'd0;
                  dir_d[1] = 1'b1;
                  hx_d     = 1'b1;
               end else begin
                  nx_d = x_q - 10'(speed_q);
               end
            end
            state_d = StStepY;
         end
         StStepY: begin
            ny_d = y_q;
            hy_d = 1'b0;
            if (speed_q != 3'd0) begin
               if (dir_q[0]) begin
                  if (y_w + spd_w >= YMax) begin
                     ny_d     = YMax[8:0];
                     dir_d[0] = 1'b0;
                     hy_d     = 1'b1;
                  end else begin
                     ny_d = y_q + 9'(speed_q);
                  end
               end else if (y_w <= spd_w) begin
                  ny_d     = 9'd0;
                  dir_d[0] = 1'b1;
                  hy_d     = 1'b1;
               end else begin
                  ny_d = y_q - 9'(speed_q);
               end
            end
            state_d = StCommit;
         end
         StCommit: begin
            x_d = nx_q;
            y_d = ny_q;
            if (hx_q || hy_q) begin
               color_d  = (color_q == 3'(N_COLORS - 1)) ? 3'd0 : color_q + 3'd1;
               bounce_d = 1'b1;
            end
            corner_d = hx_q & hy_q;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Ticks during an update coalesce into a single pending request.
      if (tick_run && (state_q != StIdle)) begin
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         frame_q   <= 32'd0;
         armed_q   <= 1'b0;
         pending_q <= 1'b0;
         x_q       <= 10'(START_X);
         y_q       <= 9'(START_Y);
         nx_q      <= 10'd0;
         ny_q      <= 9'd0;
         hx_q      <= 1'b0;
         hy_q      <= 1'b0;
         dir_q     <= 2'b11;
         speed_q   <= 3'(SPEED);
         color_q   <= 3'd0;
         bounce_q  <= 1'b0;
         corner_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         frame_q   <= frame;
         armed_q   <= 1'b1;
         pending_q <= pending_d;
         x_q       <= x_d;
         y_q       <= y_d;
         nx_q      <= nx_d;
         ny_q      <= ny_d;
         hx_q      <= hx_d;
         hy_q      <= hy_d;
         dir_q     <= dir_d;
         speed_q   <= speed_d;
         color_q   <= color_d;
         bounce_q  <= bounce_d;
         corner_q  <= corner_d;
      end
   end

   assign sprite_x  = x_q;
   assign sprite_y  = y_q;
   assign color_idx = color_q;
   assign bounce    = bounce_q;
   assign corner    = corner_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_bounce_controller.sv
// Self-checking bench for bounce_controller: directed scenarios plus a randomized
// phase, all predicted by a small position/direction/colour model.
module tb_bounce_controller;

   localparam int XMAX = 576;
   localparam int YMAX = 448;
   localparam int NCOL = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] frame;
   logic        pause;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [9:0]  cfg_x;
   logic [8:0]  cfg_y;
   logic [2:0]  cfg_speed;
   logic [1:0]  cfg_dir;
   logic [9:0]  sprite_x;
   logic [8:0]  sprite_y;
   logic [2:0]  color_idx;
   logic        bounce;
   logic        corner;
   logic        busy;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int m_x, m_y, m_spd, m_col;
   bit m_dx, m_dy;

   bounce_controller dut (
      .clk       (clk),
      .rst       (rst),
      .frame     (frame),
      .pause     (pause),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_x     (cfg_x),
      .cfg_y     (cfg_y),
      .cfg_speed (cfg_speed),
      .cfg_dir   (cfg_dir),
      .sprite_x  (sprite_x),
      .sprite_y  (sprite_y),
      .color_idx (color_idx),
      .bounce    (bounce),
      .corner    (corner),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      m_x = 0; m_y = 0; m_spd = 1; m_col = 0; m_dx = 1'b1; m_dy = 1'b1;
   endfunction

   // One axis of one frame: move by sp, stop at the limit and reverse on contact.
   function automatic void axis(input int p, input bit d, input int lim, input int sp,
                                output int np, output bit nd, output bit hit);
      np = p; nd = d; hit = 1'b0;
      if (sp == 0) return;
      if (d) begin
         if (p + sp >= lim) begin np = lim; nd = 1'b0; hit = 1'b1; end
         else np = p + sp;
      end else begin
         if (p - sp <= 0) begin np = 0; nd = 1'b1; hit = 1'b1; end
         else np = p - sp;
      end
   endfunction

   function automatic void model_frame(output bit hb, output bit hc);
      int nx, ny;
      bit hx, hy;
      axis(m_x, m_dx, XMAX, m_spd, nx, m_dx, hx);
      axis(m_y, m_dy, YMAX, m_spd, ny, m_dy, hy);
      m_x = nx; m_y = ny;
      if (hx || hy) m_col = (m_col + 1) % NCOL;
      hb = hx | hy;
      hc = hx & hy;
   endfunction

   task automatic do_update(input string tag);
      bit eb, ec;
      model_frame(eb, ec);
      @(negedge clk);
      frame = frame + 1;
      #1;
      total++;
      if (cfg_ready !== 1'b0) begin
         bad++;
         $display("FAIL %s ready_on_tick: got %0b want 0", tag, cfg_ready);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (busy !== 1'b1) begin
            bad++;
            $display("FAIL %s busy_cycle%0d: got %0b want 1", tag, i + 1, busy);
         end
      end
      @(negedge clk);
      total++;
      if ({sprite_x, sprite_y, color_idx, bounce, corner, busy} !==
          {10'(m_x), 9'(m_y), 3'(m_col), eb, ec, 1'b0}) begin
         bad++;
         $display("FAIL %s result: got x=%0d y=%0d col=%0d b=%0b c=%0b busy=%0b want x=%0d y=%0d col=%0d b=%0b c=%0b busy=0",
                  tag, sprite_x, sprite_y, color_idx, bounce, corner, busy,
                  m_x, m_y, m_col, eb, ec);
      end
      @(negedge clk);
      total++;
      if ({bounce, corner} !== 2'b00) begin
         bad++;
         $display("FAIL %s pulse_width: got b=%0b c=%0b want 0 0", tag, bounce, corner);
      end
   endtask

   task automatic do_cfg(input int x, input int y, input int s, input int d, input string tag);
      @(negedge clk);
      cfg_x = 10'(x); cfg_y = 9'(y); cfg_speed = 3'(s); cfg_dir = 2'(d);
      cfg_valid = 1'b1;
      #1;
      total++;
      if (cfg_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s cfg_ready: got %0b want 1", tag, cfg_ready);
      end
      @(posedge clk);
      #1 cfg_valid = 1'b0;
      m_x = (x > XMAX) ? XMAX : x;
      m_y = (y > YMAX) ? YMAX : y;
      m_spd = s; m_dx = d[1]; m_dy = d[0];
      @(negedge clk);
      total++;
      if ({sprite_x, sprite_y, color_idx, bounce, corner, busy} !==
          {10'(m_x), 9'(m_y), 3'(m_col), 3'b000}) begin
         bad++;
         $display("FAIL %s cfg_load: got x=%0d y=%0d col=%0d b=%0b c=%0b busy=%0b want x=%0d y=%0d col=%0d 0 0 0",
                  tag, sprite_x, sprite_y, color_idx, bounce, corner, busy, m_x, m_y, m_col);
      end
   endtask

   task automatic test_reset();
      #3 rst = 1'b0;
      #4;
      total++;
      if ({sprite_x, sprite_y, color_idx, bounce, corner, busy, cfg_ready} !== 26'd0) begin
         bad++;
         $display("FAIL reset_values: got x=%0d y=%0d col=%0d b=%0b c=%0b busy=%0b rdy=%0b want all 0",
                  sprite_x, sprite_y, color_idx, bounce, corner, busy, cfg_ready);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
   endtask

   task automatic test_first_update();
      do_update("first_update");
      total++;
      if (sprite_x !== 10'd1 || sprite_y !== 9'd1) begin
         bad++;
         $display("FAIL first_pos: got %0d,%0d want 1,1", sprite_x, sprite_y);
      end
   endtask

   task automatic test_edge_bounce();
      do_cfg(574, 10, 4, 3, "edge_cfg");
      do_update("edge_hit");
      do_update("edge_after");
      total++;
      if (sprite_x !== 10'd572) begin
         bad++;
         $display("FAIL edge_reflect: got x=%0d want 572", sprite_x);
      end
   endtask

   task automatic test_corner_wrap();
      for (int i = 0; i < 6; i++) begin
         do_cfg(576, 448, 2, 3, "corner_cfg");
         do_update("corner_hit");
      end
   endtask

   task automatic test_speed_zero();
      do_cfg(576, 0, 0, 3, "spd0_cfg");
      do_update("spd0_max");
      do_cfg(0, 448, 0, 0, "spd0_cfg2");
      do_update("spd0_zero");
   endtask

   task automatic test_pause();
      pause = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         frame = frame + 1;
         @(negedge clk);
         total++;
         if (busy !== 1'b0) begin
            bad++;
            $display("FAIL pause_busy%0d: got %0b want 0", i, busy);
         end
      end
      @(negedge clk);
      pause = 1'b0;
      total++;
      if (sprite_x !== 10'(m_x) || sprite_y !== 9'(m_y)) begin
         bad++;
         $display("FAIL pause_hold: got %0d,%0d want %0d,%0d", sprite_x, sprite_y, m_x, m_y);
      end
      do_update("unpause");
   endtask

   task automatic test_back_to_back();
      bit eb, ec;
      do_cfg(700, 20, 3, 1, "b2b_cfg");
      total++;
      if (sprite_x !== 10'd576) begin
         bad++;
         $display("FAIL cfg_clamp: got x=%0d want 576", sprite_x);
      end
      model_frame(eb, ec);
      model_frame(eb, ec);
      @(negedge clk);
      frame = frame + 1;
      #1;
      total++;
      if (cfg_ready !== 1'b0) begin
         bad++;
         $display("FAIL b2b_ready0: got %0b want 0", cfg_ready);
      end
      @(negedge clk);
      frame = frame + 1;
      #1;
      total++;
      if (cfg_ready !== 1'b0) begin
         bad++;
         $display("FAIL b2b_ready1: got %0b want 0", cfg_ready);
      end
      for (int i = 2; i < 8; i++) begin
         @(negedge clk);
         total++;
         if (cfg_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ready%0d: got %0b want 0", i, cfg_ready);
         end
      end
      @(negedge clk);
      total++;
      if ({sprite_x, sprite_y, color_idx, busy, cfg_ready} !==
          {10'(m_x), 9'(m_y), 3'(m_col), 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL b2b_result: got x=%0d y=%0d col=%0d busy=%0b rdy=%0b want x=%0d y=%0d col=%0d busy=0 rdy=1",
                  sprite_x, sprite_y, color_idx, busy, cfg_ready, m_x, m_y, m_col);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      frame = frame + 1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if ({sprite_x, sprite_y, color_idx, bounce, corner, busy, cfg_ready} !== 26'd0) begin
         bad++;
         $display("FAIL midreset_values: got x=%0d y=%0d col=%0d busy=%0b rdy=%0b want all 0",
                  sprite_x, sprite_y, color_idx, busy, cfg_ready);
      end
      @(negedge clk);
      rst = 1'b1;
      frame = frame + 1;
      model_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (busy !== 1'b0 || sprite_x !== 10'd0 || sprite_y !== 9'd0) begin
            bad++;
            $display("FAIL midreset_idle%0d: got busy=%0b x=%0d y=%0d want 0 0 0",
                     i, busy, sprite_x, sprite_y);
         end
      end
      do_update("post_reset");
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0: do_cfg(int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), "rnd_cfg");
            1, 2: do_update("rnd_update");
            default: begin
               @(negedge clk);
               pause = 1'b1;
               frame = frame + 1;
               repeat (2) @(negedge clk);
               pause = 1'b0;
               total++;
               if (busy !== 1'b0 || sprite_x !== 10'(m_x) || sprite_y !== 9'(m_y)) begin
                  bad++;
                  $display("FAIL rnd_pause: got busy=%0b x=%0d y=%0d want 0 %0d %0d",
                           busy, sprite_x, sprite_y, m_x, m_y);
               end
            end
         endcase
      end
   endtask

   initial begin
      rst = 1'b1;
      frame = 32'd0;
      pause = 1'b0;
      cfg_valid = 1'b0;
      cfg_x = '0; cfg_y = '0; cfg_speed = '0; cfg_dir = '0;
      test_reset();
      test_first_update();
      test_edge_bounce();
      test_corner_wrap();
      test_speed_zero();
      test_pause();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
